// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap controller: mstatus/mie/mepc/mcause CSRs, a three-state request FSM and the trap vector.
// Optional feature macro IRQ_VECTORED_EN selects vectored trap_pc while in HANDLER.
module irq_trap_ctrl #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] MTVEC_BASE = 32'h0000_0100
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mtip,
    input  logic            msip,
    input  logic            meip,
    input  logic            csr_we,
    input  logic [1:0]      csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] pc,
    output logic            irq_req,
    input  logic            irq_ack,
    output logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    output logic [XLEN-1:0] mret_pc,
    output logic            mtie
);

    typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

    state_t          state, state_n;
    logic            mst_mie, mst_mpie;
    logic            mie_msie, mie_mtie, mie_meie;
    logic [XLEN-1:2] mepc_q;
    logic            mcause_irq;
    logic [3:0]      mcause_code;
    logic [3:0]      code_lat;

    logic [2:0]      pend_q;
    logic [3:0]      win_code;
    logic            lat_pend;
    logic            csr_clr_mie;
    logic            take_ack;
    logic            latch;
    logic            unused_bits;

    assign unused_bits = ^{csr_wdata, pc[1:0]};

    // pend_q order is {external, software, timer}, highest priority first
    assign pend_q = {meip & mie_meie, msip & mie_msie, mtip & mie_mtie} & {3{mst_mie}};

    always_comb begin
        win_code = 4'd7;
        if (pend_q[2])      win_code = 4'd11;
        else if (pend_q[1]) win_code = 4'd3;
    end

    always_comb begin
        case (code_lat)
            4'd11:   lat_pend = pend_q[2];
            4'd3:    lat_pend = pend_q[1];
            default: lat_pend = pend_q[0];
        endcase
    end

    assign csr_clr_mie = csr_we && (csr_addr == 2'd0) && !csr_wdata[3];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // the ack is checked before the withdraw conditions so a simultaneous ack wins
    always_comb begin
        state_n  = state;
        take_ack = 1'b0;
        latch    = 1'b0;
        case (state)
            IDLE: begin
                if (|pend_q) begin
                    state_n = REQ;
                    latch   = 1'b1;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_n  = HANDLER;
                    take_ack = 1'b1;
                end else if (!lat_pend || csr_clr_mie) begin
                    state_n = IDLE;
                end
            end
            HANDLER: begin
                if (mret) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // hardware updates from ack/mret take precedence over software CSR writes
    always_ff @(posedge clock) begin
        if (reset) begin
            mst_mie     <= 1'b0;
            mst_mpie    <= 1'b0;
            mie_msie    <= 1'b0;
            mie_mtie    <= 1'b0;
            mie_meie    <= 1'b0;
            mepc_q      <= '0;
            mcause_irq  <= 1'b0;
            mcause_code <= 4'd0;
            code_lat    <= 4'd0;
        end else begin
            if (latch) code_lat <= win_code;

            if (take_ack) begin
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (csr_we && csr_addr == 2'd0) begin
                mst_mie  <= csr_wdata[3];
                mst_mpie <= csr_wdata[7];
            end

            if (csr_we && csr_addr == 2'd1) begin
                mie_msie <= csr_wdata[3];
                mie_mtie <= csr_wdata[7];
                mie_meie <= csr_wdata[11];
            end

            if (take_ack)
                mepc_q <= pc[XLEN-1:2];
            else if (csr_we && csr_addr == 2'd2)
                mepc_q <= csr_wdata[XLEN-1:2];

            if (take_ack) begin
                mcause_irq  <= 1'b1;
                mcause_code <= code_lat;
            end else if (csr_we && csr_addr == 2'd3) begin
                mcause_irq  <= csr_wdata[XLEN-1];
                mcause_code <= csr_wdata[3:0];
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            2'd0: begin
                csr_rdata[3] = mst_mie;
                csr_rdata[7] = mst_mpie;
            end
            2'd1: begin
                csr_rdata[3]  = mie_msie;
                csr_rdata[7]  = mie_mtie;
                csr_rdata[11] = mie_meie;
            end
            2'd2: csr_rdata[XLEN-1:2] = mepc_q;
            default: begin
                csr_rdata[XLEN-1] = mcause_irq;
                csr_rdata[3:0]    = mcause_code;
            end
        endcase
    end

    assign irq_req = (state == REQ);
    assign mtie    = mie_mtie;
    assign mret_pc = {mepc_q, 2'b00};

`ifdef IRQ_VECTORED_EN
    assign trap_pc = (state == HANDLER)
                   ? MTVEC_BASE + {{(XLEN-6){1'b0}}, mcause_code, 2'b00}
                   : MTVEC_BASE;
`else
    assign trap_pc = MTVEC_BASE;
`endif

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed scoreboard bench for irq_trap_ctrl: stimulus queues expected values, a negedge monitor compares them.
module tb_irq_trap_ctrl;

    localparam int S_IRQ  = 0;
    localparam int S_RD   = 1;
    localparam int S_MTIE = 2;
    localparam int S_TPC  = 3;
    localparam int S_MPC  = 4;

`ifdef IRQ_VECTORED_EN
    localparam logic [31:0] TPC_TIMER = 32'h0000_011C;
`else
    localparam logic [31:0] TPC_TIMER = 32'h0000_0100;
`endif

    logic        clock = 1'b0;
    logic        reset, mtip, msip, meip, csr_we, irq_ack, mret;
    logic [1:0]  csr_addr;
    logic [31:0] csr_wdata, csr_rdata, pc, trap_pc, mret_pc;
    logic        irq_req, mtie;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    irq_trap_ctrl #(.XLEN(32), .MTVEC_BASE(32'h0000_0100)) dut (
        .clock(clock), .reset(reset), .mtip(mtip), .msip(msip), .meip(meip),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .pc(pc), .irq_req(irq_req), .irq_ack(irq_ack), .trap_pc(trap_pc),
        .mret(mret), .mret_pc(mret_pc), .mtie(mtie)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_IRQ:   return {31'd0, irq_req};
            S_RD:    return csr_rdata;
            S_MTIE:  return {31'd0, mtie};
            S_TPC:   return trap_pc;
            default: return mret_pc;
        endcase
    endfunction

    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clock);
            while (q.size() > 0) begin
                c   = q.pop_front();
                act = sample(c.sel);
                n_vec++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic csr_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        csr_addr = a;
        chk(name, S_RD, exp);
        tick();
    endtask

    initial begin
        reset = 1'b1; mtip = 0; msip = 0; meip = 0; csr_we = 0; irq_ack = 0; mret = 0;
        csr_addr = 0; csr_wdata = 0; pc = 0;
        tick(); tick();
        reset = 1'b0;

        // reset state
        chk("rst_irq", S_IRQ, 0);
        chk("rst_mtie", S_MTIE, 0);
        chk("rst_tpc", S_TPC, 32'h100);
        csr_rd("rst_mstatus", 2'd0, 0);
        csr_rd("rst_mie", 2'd1, 0);
        csr_rd("rst_mepc", 2'd2, 0);
        csr_rd("rst_mcause", 2'd3, 0);

        // timer trap
        csr_wr(2'd1, 32'h80);
        csr_wr(2'd0, 32'h08);
        mtip = 1; pc = 32'h40;
        chk("t_irq_before", S_IRQ, 0);
        chk("t_mtie", S_MTIE, 1);
        tick();
        chk("t_irq_req", S_IRQ, 1);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        chk("t_irq_after_ack", S_IRQ, 0);
        chk("t_trap_pc", S_TPC, TPC_TIMER);
        chk("t_mret_pc", S_MPC, 32'h40);
        csr_rd("t_mepc", 2'd2, 32'h40);
        csr_rd("t_mcause", 2'd3, 32'h8000_0007);
        csr_rd("t_mstatus", 2'd0, 32'h80);

        // return from handler, timer still pending
        mret = 1;
        tick();
        mret = 0;
        csr_addr = 2'd0;
        chk("r_mstatus", S_RD, 32'h88);
        chk("r_irq_1cyc", S_IRQ, 0);
        chk("r_mret_pc", S_MPC, 32'h40);
        chk("r_tpc_idle", S_TPC, 32'h100);
        tick();
        chk("r_irq_2cyc", S_IRQ, 1);

        // withdraw: drop mtip in REQ
        mtip = 0; pc = 32'h80;
        tick();
        chk("w_irq", S_IRQ, 0);
        csr_addr = 2'd2;
        chk("w_mepc", S_RD, 32'h40);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        chk("w_ack_ignored_irq", S_IRQ, 0);
        csr_rd("w_ack_ignored_mepc", 2'd2, 32'h40);

        // priority
        csr_wr(2'd1, 32'h888);
        csr_rd("p_mie", 2'd1, 32'h888);
        mtip = 1; msip = 1; meip = 1;
        tick();
        chk("p_irq", S_IRQ, 1);
        irq_ack = 1;
        tick();
        irq_ack = 0; meip = 0;
        csr_rd("p_mcause_ext", 2'd3, 32'h8000_000B);
        mret = 1;
        tick();
        mret = 0;
        tick();
        chk("p_irq_sw", S_IRQ, 1);
        meip = 1;
        tick();
        chk("p_hold_req", S_IRQ, 1);
        irq_ack = 1; pc = 32'hC6;
        csr_we = 1; csr_addr = 2'd2; csr_wdata = 32'h1234;
        tick();
        irq_ack = 0; csr_we = 0;
        csr_rd("p_mcause_sw", 2'd3, 32'h8000_0003);
        csr_rd("p_mepc_hw_wins", 2'd2, 32'h0000_00C4);
        csr_rd("p_mstatus", 2'd0, 32'h80);

        // reset mid-REQ
        meip = 0; msip = 0;
        mret = 1;
        tick();
        mret = 0;
        tick();
        chk("x_irq_before", S_IRQ, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("x_irq", S_IRQ, 0);
        chk("x_mtie", S_MTIE, 0);
        csr_rd("x_mstatus", 2'd0, 0);
        csr_rd("x_mie", 2'd1, 0);
        csr_rd("x_mepc", 2'd2, 0);
        csr_rd("x_mcause", 2'd3, 0);
        csr_wr(2'd1, 32'h80);
        tick();
        chk("x_mtip_ignored", S_IRQ, 0);
        csr_wr(2'd0, 32'h08);
        tick();
        chk("x_irq_rearm", S_IRQ, 1);

        // CSR write clearing MIE withdraws the request
        csr_wr(2'd0, 32'h00);
        chk("c_withdraw", S_IRQ, 0);

        // write-ignore fields
        mtip = 0;
        csr_wr(2'd1, 32'hFFFF_FFFF);
        csr_rd("m_mie", 2'd1, 32'h888);
        csr_wr(2'd2, 32'hFFFF_FFFF);
        csr_rd("m_mepc", 2'd2, 32'hFFFF_FFFC);
        csr_wr(2'd3, 32'hFFFF_FFFF);
        csr_rd("m_mcause", 2'd3, 32'h8000_000F);
        csr_wr(2'd0, 32'hFFFF_FF77);
        csr_rd("m_mstatus", 2'd0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
